// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 character LCD driver.
// Holds the LCD command bytes, the top-level sequencer states, the per-byte
// transaction phases and a helper that sizes the timing counters.
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;  // display on, cursor off, no blink
  localparam logic [7:0] LCD_ENTRY    = 8'h06;  // increment address, no shift
  localparam logic [7:0] LCD_CLEAR    = 8'h01;  // clear display (slow command)
  localparam logic [7:0] LCD_LINE1    = 8'h80;  // DDRAM address 0x00
  localparam logic [7:0] LCD_LINE2    = 8'hC0;  // DDRAM address 0x40

  typedef enum logic [1:0] {
    StPwrWait,
    StInit,
    StIdle,
    StFrame
  } lcd_state_e;

  typedef enum logic [1:0] {
    PhSetup,
    PhPulse,
    PhHold
  } lcd_phase_e;

  // Width of a counter able to hold the largest of the four cycle counts.
  function automatic int unsigned lcd_cnt_width(input int unsigned a, input int unsigned b,
                                                input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Single-byte LCD write transaction engine.
// A start request latches byte/rs and plays out: one setup cycle with the
// enable low, EnPulseCycles with the enable high, then a wait with the enable
// low (ClearCycles when long_wait is set, CmdCycles otherwise). done_o is high
// in the last wait cycle so the caller can issue the next start in that same
// cycle and keep transactions back-to-back.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i                begin a transaction (overrides any one in progress)
//   byte_i, rs_i           byte and register select to put on the bus
//   long_wait_i            use the clear-command wait length
//   lcd_data_o, lcd_rs_o   bus value, held for the whole transaction
//   lcd_en_o               enable strobe (registered)
//   done_o                 last cycle of the wait
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int unsigned EnPulseCycles = 12,
  parameter int unsigned CmdCycles     = 2000,
  parameter int unsigned ClearCycles   = 82000,
  parameter int unsigned CntW          = 18
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  input  logic       rs_i,
  input  logic       long_wait_i,
  output logic [7:0] lcd_data_o,
  output logic       lcd_rs_o,
  output logic       lcd_en_o,
  output logic       done_o
);

  lcd_phase_e      phase_q, phase_d;
  logic            busy_q, busy_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      data_q, data_d;
  logic            rs_q, rs_d;
  logic            long_q, long_d;
  logic            en_q, en_d;
  logic [CntW-1:0] wait_last;

  always_comb begin
    wait_last = long_q ? CntW'(ClearCycles - 1) : CntW'(CmdCycles - 1);
    done_o    = busy_q && (phase_q == PhHold) && (cnt_q == wait_last);

    phase_d = phase_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rs_d    = rs_q;
    long_d  = long_q;

    if (start_i) begin
      busy_d  = 1'b1;
      phase_d = PhSetup;
      cnt_d   = '0;
      data_d  = byte_i;
      rs_d    = rs_i;
      long_d  = long_wait_i;
    end else if (busy_q) begin
      unique case (phase_q)
        PhSetup: begin
          phase_d = PhPulse;
          cnt_d   = '0;
        end
        PhPulse: begin
          if (cnt_q == CntW'(EnPulseCycles - 1)) begin
            phase_d = PhHold;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        PhHold: begin
          if (done_o) begin
            busy_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: phase_d = PhHold;
      endcase
    end

    // Enable is registered so it cannot glitch on phase decode.
    en_d = busy_d && (phase_d == PhPulse);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= PhHold;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
      rs_q    <= 1'b0;
      long_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      long_q  <= long_d;
      en_q    <= en_d;
    end
  end

  assign lcd_data_o = data_q;
  assign lcd_rs_o   = rs_q;
  assign lcd_en_o   = en_q;

endmodule

// File: rtl/lcd_display_driver.sv
// HD44780 2-line character LCD driver.
// Waits out LCD power-up, sends the init command sequence, then repeatedly
// copies a snapshot of the packed character buffer to the display: line-1
// address, first half of the characters, line-2 address, second half.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   DisplayBuffer    packed characters, char 0 in the most significant byte
//   RefreshEn        run frames back-to-back while high (sampled between frames)
//   LcdData, LcdRs   LCD DB7..DB0 and register select (1 = character data)
//   LcdRw            always 0, the bus is write-only
//   LcdEn            LCD enable strobe
//   Ready            init sequence complete, held until reset
//   FrameDone        one-cycle pulse at the end of each frame
module lcd_display_driver
  import lcd_pkg::*;
#(
  parameter int unsigned DisplayBufferSize = 256,
  parameter int unsigned PowerUpCycles     = 750000,
  parameter int unsigned EnPulseCycles     = 12,
  parameter int unsigned CmdCycles         = 2000,
  parameter int unsigned ClearCycles       = 82000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DisplayBufferSize-1:0] DisplayBuffer,
  input  logic                         RefreshEn,
  output logic [7:0]                   LcdData,
  output logic                         LcdRs,
  output logic                         LcdRw,
  output logic                         LcdEn,
  output logic                         Ready,
  output logic                         FrameDone
);

  localparam int unsigned CntW =
      lcd_cnt_width(PowerUpCycles, ClearCycles, CmdCycles, EnPulseCycles);
  localparam int unsigned NumChars  = DisplayBufferSize / 8;
  localparam int unsigned HalfChars = NumChars / 2;
  // Frame index runs 0..NumChars+2 (two address commands plus the chars).
  localparam int unsigned IdxW = $clog2(NumChars + 3);

  if (PowerUpCycles == 0 || EnPulseCycles == 0 || CmdCycles == 0 || ClearCycles == 0)
  begin : g_bad_cycles
    $error("lcd_display_driver: cycle count parameters must be non-zero");
  end
  if ((DisplayBufferSize % 16) != 0 || DisplayBufferSize == 0 || DisplayBufferSize > 640)
  begin : g_bad_size
    $error("lcd_display_driver: DisplayBufferSize must be a non-zero multiple of 16, <= 640");
  end

  lcd_state_e                   state_q, state_d;
  logic [CntW-1:0]              pwr_cnt_q, pwr_cnt_d;
  logic [IdxW-1:0]              idx_q, idx_d;
  logic [DisplayBufferSize-1:0] frame_q, frame_d;
  logic                         ready_q, ready_d;
  logic                         frame_done_q, frame_done_d;

  logic                         wr_start;
  logic [7:0]                   wr_byte;
  logic                         wr_rs;
  logic                         wr_long;
  logic                         wr_done;
  logic [IdxW-1:0]              char_idx;
  logic [7:0]                   char_byte;

  // idx_q counts bytes already issued in the current init or frame sequence.
  always_comb begin
    char_idx = (idx_q <= IdxW'(HalfChars)) ? idx_q - IdxW'(1) : idx_q - IdxW'(2);
    char_byte = '0;
    for (int unsigned k = 0; k < NumChars; k++) begin
      if (char_idx == IdxW'(k)) char_byte = frame_q[(NumChars-1-k)*8 +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    pwr_cnt_d    = pwr_cnt_q;
    idx_d        = idx_q;
    frame_d      = frame_q;
    ready_d      = ready_q;
    frame_done_d = 1'b0;
    wr_start     = 1'b0;
    wr_byte      = '0;
    wr_rs        = 1'b0;

    unique case (state_q)
      StPwrWait: begin
        if (pwr_cnt_q == CntW'(PowerUpCycles - 1)) begin
          wr_start  = 1'b1;
          wr_byte   = LCD_FUNC_SET;
          idx_d     = IdxW'(1);
          pwr_cnt_d = '0;
          state_d   = StInit;
        end else begin
          pwr_cnt_d = pwr_cnt_q + CntW'(1);
        end
      end
      StInit: begin
        if (wr_done) begin
          if (idx_q == IdxW'(4)) begin
            ready_d = 1'b1;
            state_d = StIdle;
          end else begin
            wr_start = 1'b1;
            wr_byte  = (idx_q == IdxW'(1)) ? LCD_DISP_ON :
                       (idx_q == IdxW'(2)) ? LCD_ENTRY : LCD_CLEAR;
            idx_d    = idx_q + IdxW'(1);
          end
        end
      end
      StIdle: begin
        if (RefreshEn) begin
          frame_d  = DisplayBuffer;
          wr_start = 1'b1;
          wr_byte  = LCD_LINE1;
          idx_d    = IdxW'(1);
          state_d  = StFrame;
        end
      end
      StFrame: begin
        if (wr_done) begin
          if (idx_q == IdxW'(NumChars + 2)) begin
            frame_done_d = 1'b1;
            state_d      = StIdle;
          end else begin
            wr_start = 1'b1;
            if (idx_q == IdxW'(HalfChars + 1)) begin
              wr_byte = LCD_LINE2;
            end else begin
              wr_byte = char_byte;
              wr_rs   = 1'b1;
            end
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      default: state_d = StPwrWait;
    endcase

    // Only the clear command needs the long wait; a 0x01 character does not.
    wr_long = !wr_rs && (wr_byte == LCD_CLEAR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StPwrWait;
      pwr_cnt_q    <= '0;
      idx_q        <= '0;
      frame_q      <= '0;
      ready_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pwr_cnt_q    <= pwr_cnt_d;
      idx_q        <= idx_d;
      frame_q      <= frame_d;
      ready_q      <= ready_d;
      frame_done_q <= frame_done_d;
    end
  end

  lcd_byte_writer #(
    .EnPulseCycles(EnPulseCycles),
    .CmdCycles    (CmdCycles),
    .ClearCycles  (ClearCycles),
    .CntW         (CntW)
  ) u_byte_writer (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (wr_start),
    .byte_i     (wr_byte),
    .rs_i       (wr_rs),
    .long_wait_i(wr_long),
    .lcd_data_o (LcdData),
    .lcd_rs_o   (LcdRs),
    .lcd_en_o   (LcdEn),
    .done_o     (wr_done)
  );

  assign LcdRw     = 1'b0;
  assign Ready     = ready_q;
  assign FrameDone = frame_done_q;

endmodule

// File: doc/lcd_display_driver.md
Name: lcd_display_driver

Overview:
- Downstream consumer of the data memory's memory-mapped display buffer.
- Continuously copies the packed character buffer (written by CPU stores with MEMTYPE=1) to an HD44780-compatible 2-line character LCD over its 8-bit parallel write-only bus.
- Owns the LCD power-up and init sequence, per-byte enable-pulse timing, and frame refresh.
- Sits at the top level between the memory block's DisplayBuffer output and the board LCD pins.

Parameters:
- DisplayBufferSize, 256: width of packed buffer in bits. Must be a multiple of 16 and ≤ 640. Chars per line is DisplayBufferSize/16.
- PowerUpCycles, 750000: clk cycles waited after reset before the first command.
- EnPulseCycles, 12: clk cycles LcdEn is held high per byte.
- CmdCycles, 2000: clk cycles waited after LcdEn falls, for all bytes except clear.
- ClearCycles, 82000: clk cycles waited after LcdEn falls for the clear command (0x01).

Ports:
- clk, input, 1: system clock. Rising edge is active.
- rst_n, input, 1: asynchronous, active-low reset.
- DisplayBuffer, input, DisplayBufferSize: packed characters. Char k (k=0..N-1, N=DisplayBufferSize/8) is DisplayBuffer[DisplayBufferSize-1-8k -: 8], so char 0 is the MSB byte.
- RefreshEn, input, 1: when high, frames repeat back-to-back. When low, the block idles at a frame boundary.
- LcdData, output, 8: LCD DB7..DB0.
- LcdRs, output, 1: 0 = command, 1 = character data.
- LcdRw, output, 1: tied 0 (write only).
- LcdEn, output, 1: LCD enable strobe.
- Ready, output, 1: high once the init sequence has completed; stays high until reset.
- FrameDone, output, 1: one-cycle pulse after the last byte of a frame completes its wait.

Behaviour:
- Reset (async, rst_n low):
  - LcdData=0, LcdRs=0, LcdRw=0, LcdEn=0, Ready=0, FrameDone=0. All counters 0; FSM in PWR_WAIT.
  - LcdEn drops in the same instant reset asserts, including mid-pulse. After release, the full init sequence reruns.
- Byte transaction (the unit of all LCD traffic):
  - T0: LcdData and LcdRs driven, LcdEn=0. This is a 1-cycle setup.
  - T1..T(EnPulseCycles): LcdEn=1.
  - Then LcdEn=0 for the wait count: ClearCycles if the byte is the command 0x01, else CmdCycles.
  - LcdData and LcdRs are held for the whole transaction and change only at the next T0.
  - Total length is 1 + EnPulseCycles + wait. Transactions are back-to-back with no gap cycle.
- FSM states and transitions:
  - PWR_WAIT: count PowerUpCycles, then go to INIT.
  - INIT: send commands 0x38 (8-bit, 2 lines), 0x0C (display on, cursor off), 0x06 (increment, no shift), 0x01 (clear), all with RS=0. Ready rises in the cycle after the clear's wait ends. Then go to IDLE.
  - IDLE: if RefreshEn=1, snapshot DisplayBuffer into an internal frame register and go to FRAME. Otherwise stay.
  - FRAME: send, in order:
    1. Command 0x80.
    2. Chars 0..N/2-1 with RS=1.
    3. Command 0xC0.
    4. Chars N/2..N-1 with RS=1.
  - FrameDone pulses in the cycle after the final char's wait ends, and the FSM returns to IDLE that same cycle.
  - With RefreshEn held high, the next T0 follows one IDLE cycle later.
- Snapshot rule: characters come only from the snapshot taken at IDLE exit. DisplayBuffer changes mid-frame do not appear until the next frame, so there is no tearing.
- RefreshEn is sampled only in IDLE. Deasserting it mid-frame does not abort the frame.
- Character bytes are passed through unfiltered; 0x00..0xFF are all legal.
- Counters are sized to $clog2 of the max of PowerUpCycles, ClearCycles, CmdCycles and EnPulseCycles, plus 1. A parameter value of 0 is illegal and is checked by an elaboration assertion.

Decomposition:
- Shared package lcd_pkg holds:
  - Command constants LCD_FUNC_SET=8'h38, LCD_DISP_ON=8'h0C, LCD_ENTRY=8'h06, LCD_CLEAR=8'h01, LCD_LINE1=8'h80, LCD_LINE2=8'hC0.
  - Enum for the top FSM: PWR_WAIT, INIT, IDLE, FRAME.
  - Enum for the transaction phase: SETUP, PULSE, HOLD.
- One sub-module, lcd_byte_writer:
  - Inputs: start, byte, rs, long_wait.
  - Outputs: LcdData, LcdRs, LcdEn, done (1-cycle pulse at the end of the wait).
  - Owns the EnPulseCycles / CmdCycles / ClearCycles counters.
- The top level sequences bytes and the frame index only.

Test Plan (bench parameters: PowerUpCycles=10, EnPulseCycles=2, CmdCycles=4, ClearCycles=20; transaction = 7 cycles, clear = 23):
- Init: release rst_n.
  - LcdEn stays 0 for 10 cycles.
  - Then bytes 0x38, 0x0C, 0x06, 0x01 with RS=0, each LcdEn high for exactly 2 cycles.
  - Ready rises 10+21+23 = 54 cycles after release, plus the 1-cycle rule.
- Frame order: DisplayBuffer = ASCII "ABCDEFGHIJKLMNOPabcdefghijklmnop" with 'A' in the MSB byte, RefreshEn=1.
  - Bus shows 0x80, 0x41..0x50 (RS=1), 0xC0, 0x61..0x70 (RS=1).
  - FrameDone pulses once after 34×7 = 238 cycles.
- Snapshot: change DisplayBuffer to all 0x2A at char 5 of a frame.
  - The current frame still emits the original chars.
  - The next frame emits 0x2A ×32.
- RefreshEn: drop RefreshEn mid-frame.
  - The frame completes, FrameDone pulses, and LcdEn stays 0 thereafter.
  - Reasserting it restarts with 0x80 one cycle later.
- Reset mid-pulse: assert rst_n=0 while LcdEn=1.
  - LcdEn=0 and Ready=0 immediately, without waiting for a clock edge.
  - After release, the full PWR_WAIT and INIT sequence repeats.
- Clear timing: measure from LcdEn falling on 0x01 to Ready rising.
  - Must be exactly 20 wait cycles plus 1; every other command waits 4.
